// File: rtl/hazard_unit_md.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit_md
// Purpose  : D-stage hazard/stall unit for the 5-stage pipeline. Compares the
//            D-stage source registers, tagged with pre-decoded Tuse values,
//            against the E/M destinations and their Tnew values. Tracks
//            multiply/divide unit occupancy and counts stall cycles in a
//            saturating performance counter.
// Ports    : clk, reset (sync, active-high)
//            D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_md_use -- D-stage sources
//            E_A3, E_tnew, E_md_start, E_md_is_div      -- E-stage producer
//            M_A3, M_tnew                               -- M-stage producer
//            stall     -- freeze PC and F/D, clear D/E (combinational)
//            md_busy   -- MDU busy counter non-zero (registered)
//            stall_cnt -- saturating count of stalled cycles
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit_md #(
    parameter int T_W         = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        D_rs,
    input  logic [4:0]        D_rt,
    input  logic [T_W-1:0]    D_rs_tuse,
    input  logic [T_W-1:0]    D_rt_tuse,
    input  logic              D_md_use,
    input  logic [4:0]        E_A3,
    input  logic [T_W-1:0]    E_tnew,
    input  logic              E_md_start,
    input  logic              E_md_is_div,
    input  logic [4:0]        M_A3,
    input  logic [T_W-1:0]    M_tnew,
    output logic              stall,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0]  c_mult_load = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0]  c_div_load  = CNT_W'(DIV_CYCLES);
    localparam logic [PERF_W-1:0] c_perf_max  = '1;

    logic [CNT_W-1:0]  r_md_cnt;
    logic [PERF_W-1:0] r_stall_cnt;
    logic              w_stall_rs;
    logic              w_stall_rt;
    logic              w_stall_md;
    logic              w_md_busy;

    // A producer only blocks D when its result arrives later than D needs it;
    // equal Tnew/Tuse is resolved by forwarding. Register 0 is never a hazard.
    assign w_stall_rs = (D_rs != 5'd0) &&
                        (((D_rs == E_A3) && (E_tnew > D_rs_tuse)) ||
                         ((D_rs == M_A3) && (M_tnew > D_rs_tuse)));

    assign w_stall_rt = (D_rt != 5'd0) &&
                        (((D_rt == E_A3) && (E_tnew > D_rt_tuse)) ||
                         ((D_rt == M_A3) && (M_tnew > D_rt_tuse)));

    assign w_md_busy  = (r_md_cnt != '0);

    // E_md_start covers the cycle the mult/div sits in E, before the counter
    // has been loaded.
    assign w_stall_md = D_md_use && (E_md_start || w_md_busy);

    assign stall     = w_stall_rs || w_stall_rt || w_stall_md;
    assign md_busy   = w_md_busy;
    assign stall_cnt = r_stall_cnt;

    // A new start reloads rather than adds: the MDU restarts on every start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (E_md_start) begin
            r_md_cnt <= E_md_is_div ? c_div_load : c_mult_load;
        end else if (w_md_busy) begin
            r_md_cnt <= r_md_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != c_perf_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_md.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit_md
// Purpose  : Self-checking bench for hazard_unit_md (PERF_W=4 so saturation
//            of the stall counter is reachable). A reference model pushes the
//            expected stall/md_busy/stall_cnt per cycle into a scoreboard that
//            is popped and compared mid-cycle; directed values are checked on
//            top at the interesting points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit_md;

    localparam int c_mult = 5;
    localparam int c_div  = 10;
    localparam int c_perf_w = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_A3, M_A3;
    logic [1:0] D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic       D_md_use, E_md_start, E_md_is_div;
    logic       stall, md_busy;
    logic [c_perf_w-1:0] stall_cnt;

    typedef struct packed {
        logic                stall;
        logic                md_busy;
        logic [c_perf_w-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   m_cnt  = 0;
    int   m_perf = 0;
    int   checks = 0;
    int   errors = 0;

    hazard_unit_md #(
        .T_W(2), .MULT_CYCLES(c_mult), .DIV_CYCLES(c_div),
        .CNT_W(4), .PERF_W(c_perf_w)
    ) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
        .D_md_use(D_md_use),
        .E_A3(E_A3), .E_tnew(E_tnew), .E_md_start(E_md_start),
        .E_md_is_div(E_md_is_div),
        .M_A3(M_A3), .M_tnew(M_tnew),
        .stall(stall), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic model_stall();
        logic rs_h, rt_h, md_h;
        rs_h = (D_rs != 0) && (((D_rs == E_A3) && (E_tnew > D_rs_tuse)) ||
                               ((D_rs == M_A3) && (M_tnew > D_rs_tuse)));
        rt_h = (D_rt != 0) && (((D_rt == E_A3) && (E_tnew > D_rt_tuse)) ||
                               ((D_rt == M_A3) && (M_tnew > D_rt_tuse)));
        md_h = D_md_use && (E_md_start || (m_cnt != 0));
        return rs_h || rt_h || md_h;
    endfunction

    task automatic idle();
        reset = 1'b0;
        D_rs = 0; D_rt = 0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3; D_md_use = 0;
        E_A3 = 0; E_tnew = 0; E_md_start = 0; E_md_is_div = 0;
        M_A3 = 0; M_tnew = 0;
    endtask

    // One clock cycle with the inputs currently driven. es/eb/ec are directed
    // expectations for stall/md_busy/stall_cnt (-1 = not checked directly).
    task automatic cycle(input string tag, input int es, input int eb, input int ec);
        exp_t e;
        e.stall   = model_stall();
        e.md_busy = (m_cnt != 0);
        e.cnt     = c_perf_w'(m_perf);
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        assert (stall === e.stall) else begin
            errors++;
            $error("FAIL %s stall observed=%b expected=%b", tag, stall, e.stall);
        end
        checks++;
        assert (md_busy === e.md_busy) else begin
            errors++;
            $error("FAIL %s md_busy observed=%b expected=%b", tag, md_busy, e.md_busy);
        end
        checks++;
        assert (stall_cnt === e.cnt) else begin
            errors++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, e.cnt);
        end
        if (es >= 0) begin
            checks++;
            assert (stall === 1'(es)) else begin
                errors++;
                $error("FAIL %s directed stall observed=%b expected=%0d", tag, stall, es);
            end
        end
        if (eb >= 0) begin
            checks++;
            assert (md_busy === 1'(eb)) else begin
                errors++;
                $error("FAIL %s directed md_busy observed=%b expected=%0d", tag, md_busy, eb);
            end
        end
        if (ec >= 0) begin
            checks++;
            assert (stall_cnt === c_perf_w'(ec)) else begin
                errors++;
                $error("FAIL %s directed stall_cnt observed=%0d expected=%0d", tag, stall_cnt, ec);
            end
        end
        @(posedge clk);
        if (reset) begin
            m_cnt  = 0;
            m_perf = 0;
        end else begin
            if (E_md_start)   m_cnt = E_md_is_div ? c_div : c_mult;
            else if (m_cnt != 0) m_cnt = m_cnt - 1;
            if (e.stall && m_perf != (1 << c_perf_w) - 1) m_perf = m_perf + 1;
        end
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        cycle("reset_state", 0, 0, -1);
        reset = 1'b0;
        cycle("after_reset", 0, 0, 0);

        // lw-use, then the load has moved to M with Tnew=1
        E_A3 = 8; E_tnew = 2; D_rs = 8; D_rs_tuse = 1;
        cycle("lw_use", 1, -1, -1);
        E_A3 = 0; E_tnew = 0; M_A3 = 8; M_tnew = 1;
        cycle("lw_in_M", 0, -1, -1);

        // beq after add on rt; register 0; Tnew==Tuse; rs==rt independent
        idle(); E_A3 = 9; E_tnew = 1; D_rt = 9; D_rt_tuse = 0;
        cycle("beq_add", 1, -1, -1);
        D_rt = 0; E_A3 = 0;
        cycle("reg_zero", 0, -1, -1);
        E_A3 = 9; D_rt = 9; D_rt_tuse = 1;
        cycle("tnew_eq_tuse", 0, -1, -1);
        D_rs = 9; D_rs_tuse = 3; D_rt_tuse = 0;
        cycle("rs_eq_rt", 1, -1, -1);

        // mult then mflo
        idle(); D_md_use = 1; E_md_start = 1; E_md_is_div = 0;
        cycle("mult_t", 1, 0, -1);
        E_md_start = 0;
        for (int i = 1; i <= c_mult; i++) cycle("mult_busy", 1, 1, -1);
        cycle("mult_done", 0, 0, -1);

        // div then mfhi: 11 stall cycles
        E_md_start = 1; E_md_is_div = 1;
        cycle("div_t", 1, 0, -1);
        E_md_start = 0;
        for (int i = 1; i <= c_div; i++) cycle("div_busy", 1, 1, -1);
        cycle("div_done", 0, 0, -1);

        // non-md instruction during busy, then reset mid-divide
        E_md_start = 1; E_md_is_div = 1;
        cycle("div2_t", 1, 0, -1);
        E_md_start = 0; D_md_use = 0;
        cycle("non_md_busy", 0, 1, -1);
        D_md_use = 1;
        cycle("div2_t2", 1, 1, -1);
        reset = 1;
        cycle("div2_reset", 1, 1, -1);
        reset = 0;
        cycle("post_reset", 0, 0, 0);

        // hold a data stall for 20 cycles: counter saturates at 15
        idle(); E_A3 = 8; E_tnew = 2; D_rs = 8; D_rs_tuse = 1;
        for (int i = 0; i < 20; i++) cycle("perf_hold", 1, -1, -1);
        cycle("perf_sat", 1, -1, 15);

        // restart while busy reloads (mult twice, 2 cycles apart)
        idle(); E_md_start = 1;
        cycle("reload_t", 0, 0, 15);
        E_md_start = 0;
        cycle("reload_t1", 0, 1, -1);
        E_md_start = 1;
        cycle("reload_t2", 0, 1, -1);
        E_md_start = 0;
        for (int i = 1; i <= c_mult; i++) cycle("reload_busy", 0, 1, -1);
        cycle("reload_done", 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
